// File: rtl/post_norm_round_pipe_if.sv
// Handshake and payload bundle for the post-normalisation round stage.
// The master side is the upstream normaliser that also consumes results;
// the slave side is the rounding pipeline itself.
interface post_norm_round_pipe_if #(
   parameter int IN_W   = 50,
   parameter int MANT_W = 23,
   parameter int EXP_W  = 8,
   parameter int LP_W   = $clog2(IN_W)
);
   logic              in_valid;
   logic              in_ready;
   logic              in_sign;
   logic [EXP_W:0]    in_exp;
   logic [IN_W-1:0]   in_mant;
   logic [LP_W-1:0]   in_lead_pos;
   logic [1:0]        in_rmode;

   logic              out_valid;
   logic              out_ready;
   logic              out_sign;
   logic [EXP_W-1:0]  out_exp;
   logic [MANT_W-1:0] out_mant;
   logic              out_inexact;
   logic              out_overflow;
   logic              out_underflow;

   modport master (
      output in_valid, in_sign, in_exp, in_mant, in_lead_pos, in_rmode, out_ready,
      input  in_ready, out_valid, out_sign, out_exp, out_mant,
             out_inexact, out_overflow, out_underflow
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_mant, in_lead_pos, in_rmode, out_ready,
      output in_ready, out_valid, out_sign, out_exp, out_mant,
             out_inexact, out_overflow, out_underflow
   );
endinterface

// File: rtl/post_norm_round_pipe.sv
// Two-stage post-normalisation and rounding pipeline.
// Stage 1 left-justifies the mantissa (or stops at the denormal boundary)
// and extracts fraction/guard/sticky; stage 2 rounds, detects overflow and
// packs the result with its IEEE flags. Valid/ready on both sides.
module post_norm_round_pipe #(
   parameter int IN_W   = 50,
   parameter int MANT_W = 23,
   parameter int EXP_W  = 8,
   parameter int LP_W   = $clog2(IN_W)
) (
   input  logic                  clk,
   input  logic                  rst,
   post_norm_round_pipe_if.slave io_bus
);

   // Working width wide enough for both the exponent and the shift distance.
   localparam int CW = ((EXP_W + 1 > LP_W) ? EXP_W + 1 : LP_W) + 1;

   localparam logic [1:0] RM_RNE = 2'd0;
   localparam logic [1:0] RM_RUP = 2'd2;
   localparam logic [1:0] RM_RDN = 2'd3;

   logic              r_s1Valid;
   logic              r_s1Sign;
   logic [1:0]        r_s1Rmode;
   logic [EXP_W:0]    r_s1Exp;
   logic [MANT_W-1:0] r_s1Frac;
   logic              r_s1Guard;
   logic              r_s1Sticky;
   logic              r_s1Zero;
   logic              r_s1Big;

   logic              r_s2Valid;
   logic              r_outSign;
   logic [EXP_W-1:0]  r_outExp;
   logic [MANT_W-1:0] r_outMant;
   logic              r_outInexact;
   logic              r_outOverflow;
   logic              r_outUnderflow;

   logic              w_s2Advance;
   logic              w_inReady;

   logic [CW-1:0]     w_e;
   logic [CW-1:0]     w_d;
   logic [CW-1:0]     w_sh;
   logic [CW-1:0]     w_preExp;
   logic [IN_W-1:0]   w_m;

   logic              w_inc;
   logic              w_lost;
   logic              w_ovf;
   logic              w_toInf;
   logic [MANT_W:0]   w_sum;
   logic [EXP_W+1:0]  w_expR;
   logic [EXP_W-1:0]  w_packExp;
   logic [MANT_W-1:0] w_packMant;
   logic              w_packInexact;
   logic              w_packOverflow;
   logic              w_packUnderflow;

   // S2 takes a new beat when empty or when its current beat is leaving;
   // S1 moves in lock-step with S2, so a full pipe still streams one per cycle.
   assign w_s2Advance = !r_s2Valid | io_bus.out_ready;
   assign w_inReady   = !r_s1Valid | w_s2Advance;

   assign io_bus.in_ready      = w_inReady;
   assign io_bus.out_valid     = r_s2Valid;
   assign io_bus.out_sign      = r_outSign;
   assign io_bus.out_exp       = r_outExp;
   assign io_bus.out_mant      = r_outMant;
   assign io_bus.out_inexact   = r_outInexact;
   assign io_bus.out_overflow  = r_outOverflow;
   assign io_bus.out_underflow = r_outUnderflow;

   // Normalising shift: shift the leading one to the hidden position unless
   // that would push the exponent below 1, in which case stop at denormal.
   always_comb begin
      w_e = (io_bus.in_exp == '0) ? CW'(1) : CW'(io_bus.in_exp);
      w_d = CW'(IN_W - 1) - CW'(io_bus.in_lead_pos);
      if (w_e > w_d) begin
         w_sh     = w_d;
         w_preExp = w_e - w_d;
      end else begin
         w_sh     = w_e - CW'(1);
         w_preExp = '0;
      end
      w_m = io_bus.in_mant << w_sh;
   end

   // Stage 1 register: capture the shifted fraction, guard and sticky bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1Valid  <= 1'b0;
         r_s1Sign   <= 1'b0;
         r_s1Rmode  <= 2'd0;
         r_s1Exp    <= '0;
         r_s1Frac   <= '0;
         r_s1Guard  <= 1'b0;
         r_s1Sticky <= 1'b0;
         r_s1Zero   <= 1'b0;
         r_s1Big    <= 1'b0;
      end else if (w_inReady) begin
         r_s1Valid <= io_bus.in_valid;
         if (io_bus.in_valid) begin
            r_s1Sign   <= io_bus.in_sign;
            r_s1Rmode  <= io_bus.in_rmode;
            r_s1Exp    <= w_preExp[EXP_W:0];
            r_s1Frac   <= w_m[IN_W-2 -: MANT_W];
            r_s1Guard  <= w_m[IN_W-2-MANT_W];
            r_s1Sticky <= |w_m[IN_W-3-MANT_W:0];
            r_s1Zero   <= (io_bus.in_mant == '0);
            r_s1Big    <= io_bus.in_exp[EXP_W];
         end
      end
   end

   // Rounding, overflow saturation and result packing for stage 2.
   always_comb begin
      w_lost = r_s1Guard | r_s1Sticky;
      case (r_s1Rmode)
         RM_RNE:  w_inc = r_s1Guard & (r_s1Sticky | r_s1Frac[0]);
         RM_RUP:  w_inc = !r_s1Sign & w_lost;
         RM_RDN:  w_inc = r_s1Sign & w_lost;
         default: w_inc = 1'b0;
      endcase
      w_sum   = {1'b0, r_s1Frac} + (MANT_W+1)'(w_inc);
      w_expR  = (EXP_W+2)'(r_s1Exp) + (EXP_W+2)'(w_sum[MANT_W]);
      w_ovf   = r_s1Big | (w_expR >= {2'b00, {EXP_W{1'b1}}});
      w_toInf = (r_s1Rmode == RM_RNE) | ((r_s1Rmode == RM_RUP) & !r_s1Sign) |
                ((r_s1Rmode == RM_RDN) & r_s1Sign);

      w_packExp       = w_expR[EXP_W-1:0];
      w_packMant      = w_sum[MANT_W-1:0];
      w_packInexact   = w_lost | w_ovf;
      w_packOverflow  = w_ovf;
      w_packUnderflow = (w_expR == '0) & w_lost;

      if (r_s1Zero) begin
         w_packExp       = '0;
         w_packMant      = '0;
         w_packInexact   = 1'b0;
         w_packOverflow  = 1'b0;
         w_packUnderflow = 1'b0;
      end else if (w_ovf) begin
         w_packExp       = w_toInf ? {EXP_W{1'b1}} : {{(EXP_W-1){1'b1}}, 1'b0};
         w_packMant      = w_toInf ? '0 : {MANT_W{1'b1}};
         w_packUnderflow = 1'b0;
      end
   end

   // Stage 2 register: holds the packed result steady while downstream stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2Valid      <= 1'b0;
         r_outSign      <= 1'b0;
         r_outExp       <= '0;
         r_outMant      <= '0;
         r_outInexact   <= 1'b0;
         r_outOverflow  <= 1'b0;
         r_outUnderflow <= 1'b0;
      end else if (w_s2Advance) begin
         r_s2Valid <= r_s1Valid;
         if (r_s1Valid) begin
            r_outSign      <= r_s1Sign;
            r_outExp       <= w_packExp;
            r_outMant      <= w_packMant;
            r_outInexact   <= w_packInexact;
            r_outOverflow  <= w_packOverflow;
            r_outUnderflow <= w_packUnderflow;
         end
      end
   end

endmodule
